// File: rtl/ddr_request_scheduler.sv
// ddr_request_scheduler: round-robin arbiter that shares one MIG application
// port among NUM_CORES cores, issuing one 32-bit word access at a time as a
// 128-bit read or masked write.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_INIT   | waiting for MIG calibration; requests ignored
// S_IDLE   | pick next requester round-robin, latch its request
// S_CMD    | app_en / app_wdf_wren held until each is accepted
// S_RD_WAIT| read command accepted, waiting for app_rd_data_valid
// S_RESP   | one-cycle response pulse to the owner, then release grant
module ddr_request_scheduler #(
  parameter int NUM_CORES      = 16,
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init_calib_complete,
  input  logic [NUM_CORES-1:0]          core_req_valid,
  input  logic [NUM_CORES-1:0]          core_req_we,
  input  logic [NUM_CORES*32-1:0]       core_req_addr,
  input  logic [NUM_CORES*32-1:0]       core_req_wdata,
  output logic [NUM_CORES-1:0]          core_grant,
  output logic [NUM_CORES-1:0]          core_resp_valid,
  output logic [31:0]                   core_resp_rdata,
  output logic                          busy,
  output logic                          app_en,
  output logic [2:0]                    app_cmd,
  output logic [ADDR_WIDTH-1:0]         app_addr,
  input  logic                          app_rdy,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  output logic [APP_DATA_WIDTH-1:0]     app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0]   app_wdf_mask,
  input  logic                          app_wdf_rdy,
  input  logic                          app_rd_data_valid,
  input  logic [APP_DATA_WIDTH-1:0]     app_rd_data
);

  localparam int PTR_W = $clog2(NUM_CORES);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CMD, S_RD_WAIT, S_RESP} state_t;

  state_t                        state, state_nxt;
  logic [PTR_W-1:0]              rr_ptr, rr_ptr_nxt;
  logic [1:0]                    lane, lane_nxt;
  logic                          is_write, is_write_nxt;
  logic                          cmd_done, cmd_done_nxt;
  logic                          wdf_done, wdf_done_nxt;

  logic [NUM_CORES-1:0]          grant_nxt, resp_valid_nxt;
  logic [31:0]                   rdata_nxt;
  logic                          busy_nxt;
  logic                          app_en_nxt, wren_nxt, wend_nxt;
  logic [2:0]                    app_cmd_nxt;
  logic [ADDR_WIDTH-1:0]         app_addr_nxt;
  logic [APP_DATA_WIDTH-1:0]     wdf_data_nxt;
  logic [APP_DATA_WIDTH/8-1:0]   wdf_mask_nxt;

  logic                          arb_found;
  logic [PTR_W-1:0]              arb_idx, arb_cand;
  logic [ADDR_WIDTH-2:0]         sel_addr;   // byte address bits [ADDR_WIDTH:2]
  logic [31:0]                   sel_wdata;
  logic                          cmd_acc, wdf_acc;

  assign sel_addr  = core_req_addr[32*int'(arb_idx) + 2 +: ADDR_WIDTH-1];
  assign sel_wdata = core_req_wdata[32*int'(arb_idx) +: 32];
  assign cmd_acc   = app_en & app_rdy;
  assign wdf_acc   = app_wdf_wren & app_wdf_rdy;

  // Round-robin search: first pending core at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      arb_cand = rr_ptr + PTR_W'(i);
      if (!arb_found && core_req_valid[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    lane_nxt        = lane;
    is_write_nxt    = is_write;
    cmd_done_nxt    = cmd_done;
    wdf_done_nxt    = wdf_done;
    grant_nxt       = core_grant;
    resp_valid_nxt  = core_resp_valid;
    rdata_nxt       = core_resp_rdata;
    app_en_nxt      = app_en;
    app_cmd_nxt     = app_cmd;
    app_addr_nxt    = app_addr;
    wren_nxt        = app_wdf_wren;
    wend_nxt        = app_wdf_end;
    wdf_data_nxt    = app_wdf_data;
    wdf_mask_nxt    = app_wdf_mask;

    case (state)
      S_INIT: begin
        if (init_calib_complete) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (arb_found) begin
          is_write_nxt = core_req_we[arb_idx];
          lane_nxt     = sel_addr[1:0];
          grant_nxt    = NUM_CORES'(1) << arb_idx;
          rr_ptr_nxt   = arb_idx + PTR_W'(1);
          app_en_nxt   = 1'b1;
          app_cmd_nxt  = core_req_we[arb_idx] ? 3'b000 : 3'b001;
          // 16-bit column units, aligned to an 8-column burst
          app_addr_nxt = {sel_addr[ADDR_WIDTH-2:2], 3'b000};
          wdf_data_nxt = {(APP_DATA_WIDTH/32){sel_wdata}};
          wdf_mask_nxt = '1;
          wdf_mask_nxt[{sel_addr[1:0], 2'b00} +: 4] = 4'b0000;
          wren_nxt     = core_req_we[arb_idx];
          wend_nxt     = core_req_we[arb_idx];
          cmd_done_nxt = 1'b0;
          // a read has no data phase, so its data side starts out done
          wdf_done_nxt = ~core_req_we[arb_idx];
          state_nxt    = S_CMD;
        end
      end
      S_CMD: begin
        if (cmd_acc) app_en_nxt = 1'b0;
        if (wdf_acc) begin
          wren_nxt = 1'b0;
          wend_nxt = 1'b0;
        end
        cmd_done_nxt = cmd_done | cmd_acc;
        wdf_done_nxt = wdf_done | wdf_acc;
        if (cmd_done_nxt && wdf_done_nxt) begin
          if (is_write) begin
            resp_valid_nxt = core_grant;
            state_nxt      = S_RESP;
          end else begin
            state_nxt = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (app_rd_data_valid) begin
          rdata_nxt      = app_rd_data[{lane, 5'b00000} +: 32];
          resp_valid_nxt = core_grant;
          state_nxt      = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_nxt = '0;
        grant_nxt      = '0;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State, bookkeeping and output registers; all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_INIT;
      rr_ptr          <= '0;
      lane            <= '0;
      is_write        <= 1'b0;
      cmd_done        <= 1'b0;
      wdf_done        <= 1'b0;
      core_grant      <= '0;
      core_resp_valid <= '0;
      core_resp_rdata <= '0;
      busy            <= 1'b0;
      app_en          <= 1'b0;
      app_cmd         <= '0;
      app_addr        <= '0;
      app_wdf_wren    <= 1'b0;
      app_wdf_end     <= 1'b0;
      app_wdf_data    <= '0;
      app_wdf_mask    <= '0;
    end else begin
      state           <= state_nxt;
      rr_ptr          <= rr_ptr_nxt;
      lane            <= lane_nxt;
      is_write        <= is_write_nxt;
      cmd_done        <= cmd_done_nxt;
      wdf_done        <= wdf_done_nxt;
      core_grant      <= grant_nxt;
      core_resp_valid <= resp_valid_nxt;
      core_resp_rdata <= rdata_nxt;
      busy            <= busy_nxt;
      app_en          <= app_en_nxt;
      app_cmd         <= app_cmd_nxt;
      app_addr        <= app_addr_nxt;
      app_wdf_wren    <= wren_nxt;
      app_wdf_end     <= wend_nxt;
      app_wdf_data    <= wdf_data_nxt;
      app_wdf_mask    <= wdf_mask_nxt;
    end
  end

endmodule

// File: tb/tb_ddr_request_scheduler.sv
// Bench for ddr_request_scheduler: directed scenarios followed by random
// traffic, all compared against a small arithmetic model of the scheduler.
module tb_ddr_request_scheduler;

  localparam int N  = 16;
  localparam int AW = 28;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            init_calib_complete = 1'b0;
  logic [N-1:0]    core_req_valid = '0;
  logic [N-1:0]    core_req_we = '0;
  logic [N*32-1:0] core_req_addr = '0;
  logic [N*32-1:0] core_req_wdata = '0;
  logic [N-1:0]    core_grant;
  logic [N-1:0]    core_resp_valid;
  logic [31:0]     core_resp_rdata;
  logic            busy;
  logic            app_en;
  logic [2:0]      app_cmd;
  logic [AW-1:0]   app_addr;
  logic            app_rdy = 1'b0;
  logic            app_wdf_wren;
  logic            app_wdf_end;
  logic [127:0]    app_wdf_data;
  logic [15:0]     app_wdf_mask;
  logic            app_wdf_rdy = 1'b0;
  logic            app_rd_data_valid = 1'b0;
  logic [127:0]    app_rd_data = '0;

  int          checks = 0;
  int          failures = 0;
  int          rr_ptr = 0;        // model: next core with top priority
  logic [31:0] last_rdata = '0;   // model: last word returned by a read

  ddr_request_scheduler #(.NUM_CORES(N), .ADDR_WIDTH(AW), .APP_DATA_WIDTH(128)) dut (
    .clk                 (clk),
    .reset               (reset),
    .init_calib_complete (init_calib_complete),
    .core_req_valid      (core_req_valid),
    .core_req_we         (core_req_we),
    .core_req_addr       (core_req_addr),
    .core_req_wdata      (core_req_wdata),
    .core_grant          (core_grant),
    .core_resp_valid     (core_resp_valid),
    .core_resp_rdata     (core_resp_rdata),
    .busy                (busy),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data         (app_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int j, input bit we, input logic [31:0] a, input logic [31:0] d);
    core_req_valid[j]         = 1'b1;
    core_req_we[j]            = we;
    core_req_addr[32*j +: 32] = a;
    core_req_wdata[32*j +: 32] = d;
  endtask

  // Model arbitration: scan cores starting at rr_ptr, modulo N.
  function automatic int model_pick();
    for (int k = 0; k < N; k++)
      if (core_req_valid[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
    return -1;
  endfunction

  // One full transaction; called at a falling edge with the DUT in IDLE
  // (or INIT for the calibration case). Returns with the DUT back in IDLE.
  task automatic run_txn(input int max_wait, input int rdy_dly, input int wdf_dly,
                         input int rd_lat, input logic [127:0] line, input bit drop_early,
                         output int win, output int lat);
    int          w, n, en_cnt, wr_cnt, c, ln;
    bit          we;
    logic [31:0] a, d;
    logic [AW-1:0] exp_addr;
    logic [15:0] exp_mask;
    w = model_pick();
    win = w;
    lat = 0;
    if (w < 0) begin
      $display("FAIL tb_no_request obs=none exp=pending");
      $fatal(1, "bench issued a transaction with no request");
    end
    we       = core_req_we[w];
    a        = core_req_addr[32*w +: 32];
    d        = core_req_wdata[32*w +: 32];
    ln       = int'((a >> 2) % 4);
    exp_addr = AW'((a >> 4) * 8);
    exp_mask = 16'hFFFF ^ (16'hF << (4 * ln));

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_grant == '0 && n < max_wait);
    lat = n;
    check("grant", core_grant, N'(1) << w);
    check("busy_active", busy, 1);
    check("app_cmd", app_cmd, we ? 3'd0 : 3'd1);
    check("wren_end", {app_wdf_wren, app_wdf_end}, we ? 2'b11 : 2'b00);
    if (we) begin
      check("wdf_data", app_wdf_data, {d, d, d, d});
      check("wdf_mask", app_wdf_mask, exp_mask);
    end
    if (drop_early) core_req_valid[w] = 1'b0;

    en_cnt = 0;
    wr_cnt = 0;
    c = 0;
    while ((app_en || app_wdf_wren) && c <= 40) begin
      if (app_en) begin
        en_cnt++;
        check("addr_stable", app_addr, exp_addr);
      end
      if (app_wdf_wren) begin
        wr_cnt++;
        check("data_stable", {app_wdf_mask, app_wdf_data}, {exp_mask, d, d, d, d});
      end
      check("no_early_resp", core_resp_valid, '0);
      app_rdy     = (c >= rdy_dly);
      app_wdf_rdy = (c >= wdf_dly);
      @(negedge clk);
      c++;
      lat++;
    end
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b0;
    check("app_en_cycles", en_cnt, rdy_dly + 1);
    check("wren_cycles", wr_cnt, we ? wdf_dly + 1 : 0);

    if (!we) begin
      for (int k = 0; k < rd_lat; k++) begin
        check("rd_wait_quiet", core_resp_valid, '0);
        @(negedge clk);
        lat++;
      end
      app_rd_data_valid = 1'b1;
      app_rd_data       = line;
      @(negedge clk);
      lat++;
      app_rd_data_valid = 1'b0;
      app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
      last_rdata        = line[32*ln +: 32];
    end
    check("resp_pulse", core_resp_valid, N'(1) << w);
    check("resp_rdata", core_resp_rdata, last_rdata);
    core_req_valid[w] = 1'b0;
    rr_ptr = (w + 1) % N;
    @(negedge clk);
    check("resp_once", core_resp_valid, '0);
    check("grant_clear", core_grant, '0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int w, l;

    // reset: every output low
    #1 reset = 1'b0;
    #2;
    check("reset_outputs", {core_grant, core_resp_valid, core_resp_rdata, busy, app_en,
                            app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_mask}, '0);
    check("reset_wdf_data", app_wdf_data, '0);
    @(negedge clk);
    reset = 1'b1;

    // calibration gating: core 3 waits, nothing issues until calibration
    set_req(3, 1'b0, 32'h0000_0104, 32'h0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("calib_gate_app_en", app_en, 0);
    end
    check("init_busy", busy, 1);
    init_calib_complete = 1'b1;
    run_txn(2, 0, 0, 2, {$urandom, $urandom, $urandom, $urandom}, 1'b0, w, l);

    // masked write, minimum latency: request cycle, CMD, RESP
    set_req(5, 1'b1, 32'h0000_0038, 32'hDEAD_BEEF);
    run_txn(4, 0, 0, 0, '0, 1'b0, w, l);
    check("wr_latency", l, 2);
    check("wr_winner", w, 5);

    // read lane select: 0x24 is lane 1
    set_req(2, 1'b0, 32'h0000_0024, 32'h0);
    run_txn(4, 0, 0, 10, 128'h44443333_22221111_0000FFFF_AAAA5555, 1'b0, w, l);
    check("rd_lane_word", core_resp_rdata, 32'h0000_FFFF);

    // bring the pointer round to core 0
    set_req(15, 1'b0, $urandom, 32'h0);
    run_txn(4, 1, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, w, l);

    // fairness: all cores request continuously
    for (int j = 0; j < N; j++) set_req(j, 1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int i = 0; i < N + 1; i++) begin
      run_txn(4, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
              {$urandom, $urandom, $urandom, $urandom}, 1'b0, w, l);
      check("rr_order", w, i % N);
      set_req(w, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    core_req_valid = '0;

    // wrap: after core 15, core 0 outranks core 14
    set_req(15, 1'b1, $urandom, $urandom);
    run_txn(4, 0, 0, 0, '0, 1'b0, w, l);
    set_req(14, 1'b1, $urandom, $urandom);
    set_req(0, 1'b1, $urandom, $urandom);
    run_txn(4, 0, 0, 0, '0, 1'b0, w, l);
    check("wrap_winner", w, 0);
    core_req_valid = '0;

    // back-pressure skew, both directions
    set_req(6, 1'b1, $urandom, $urandom);
    run_txn(4, 4, 0, 0, '0, 1'b0, w, l);
    set_req(11, 1'b1, $urandom, $urandom);
    run_txn(4, 0, 4, 0, '0, 1'b0, w, l);
    set_req(12, 1'b0, $urandom, 32'h0);
    run_txn(4, 3, 0, 4, {$urandom, $urandom, $urandom, $urandom}, 1'b0, w, l);

    // requester gives up mid-transaction; response still arrives
    set_req(7, 1'b1, $urandom, $urandom);
    run_txn(4, 2, 1, 0, '0, 1'b1, w, l);

    // random traffic
    for (int t = 0; t < 30; t++) begin
      for (int j = 0; j < N; j++)
        if (!core_req_valid[j] && $urandom_range(0, 3) == 0)
          set_req(j, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (core_req_valid == '0)
        set_req(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      run_txn(4, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
              {$urandom, $urandom, $urandom, $urandom}, 1'b0, w, l);
    end
    core_req_valid = '0;

    // asynchronous reset while waiting for read data
    set_req(9, 1'b0, 32'h0000_0ABC, 32'h0);
    @(negedge clk);
    check("rst_rd_grant", core_grant, N'(1) << 9);
    app_rdy = 1'b1;
    @(negedge clk);
    app_rdy = 1'b0;
    check("rst_rd_cmd_done", app_en, 0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", {core_grant, core_resp_valid, core_resp_rdata, busy, app_en,
                                  app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_mask}, '0);
    check("async_reset_wdf_data", app_wdf_data, '0);
    core_req_valid      = '0;
    init_calib_complete = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    app_rd_data_valid = 1'b1;
    app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stale_rd_no_resp", core_resp_valid, '0);
      check("stale_rd_no_data", core_resp_rdata, '0);
    end
    app_rd_data_valid   = 1'b0;
    init_calib_complete = 1'b1;
    rr_ptr     = 0;
    last_rdata = '0;
    @(negedge clk);

    // pointer restarted at core 0: core 1 beats core 14
    set_req(14, 1'b0, $urandom, 32'h0);
    set_req(1, 1'b0, $urandom, 32'h0);
    run_txn(4, 0, 0, 3, {$urandom, $urandom, $urandom, $urandom}, 1'b0, w, l);
    check("post_reset_winner", w, 1);
    core_req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
